mul_share_arbiter: RTL and testbench

MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

---
 rtl/mul_share_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mul_share_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - N-requester arbiter for one shared 32x32 multiplier, in-order product return via tag FIFO; MUL_ARB_FIXED_PRIO_EN selects fixed priority
module mul_share_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TAG_DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_REQ-1:0]    REQ_STB,
    output logic [N_REQ-1:0]    REQ_ACK,
    input  logic [32*N_REQ-1:0] REQ_DAT_A,
    input  logic [32*N_REQ-1:0] REQ_DAT_B,
    output logic [N_REQ-1:0]    RSP_STB,
    output logic [63:0]         RSP_DAT,
    input  logic [N_REQ-1:0]    RSP_ACK,
    output logic                M_STB,
    input  logic                M_ACK,
    output logic [31:0]         M_DAT_A,
    output logic [31:0]         M_DAT_B,
    input  logic                M_RES_STB,
    output logic                M_RES_ACK,
    input  logic [63:0]         M_RES_DAT,
    output logic                ERR
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // Tag FIFO remembers which requester each in-flight product belongs to.
    logic [IDX_W-1:0] tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] head_tag;
    logic             tag_empty;
    logic             tag_full;

    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic             push;
    logic             pop;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;

    assign tag_empty = (count == '0);
    assign tag_full  = (count == CNT_W'(TAG_DEPTH));
    assign head_tag  = tag_mem[rd_ptr];

`ifdef MUL_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest-numbered active requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (REQ_STB[k]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end
`else
    localparam int                SUM_W   = IDX_W + 1;
    localparam logic [SUM_W-1:0]  N_REQ_S = SUM_W'(N_REQ);

    logic [IDX_W-1:0] last_grant;
    logic [SUM_W-1:0] cand_sum;
    logic [IDX_W-1:0] cand;

    // Round-robin: scan from the requester after the last winner, wrapping mod N_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_sum = {1'b0, last_grant} + SUM_W'(k + 1);
            cand     = (cand_sum >= N_REQ_S) ? IDX_W'(cand_sum - N_REQ_S) : IDX_W'(cand_sum);
            if (!grant_vld && REQ_STB[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Last winner moves only when a grant is actually given.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant <= IDX_W'(N_REQ - 1);
        end else if (push) begin
            last_grant <= grant_idx;
        end
    end
`endif

    // A grant needs an empty operand slot and a free tag; nothing is granted in reset.
    assign push = !RST && (state == IDLE) && !tag_full && grant_vld;

    // One-hot acknowledge to the winner, combinational with its strobe.
    always_comb begin
        REQ_ACK = '0;
        if (push) begin
            REQ_ACK[grant_idx] = 1'b1;
        end
    end

    // Pick the winner's operands out of the packed buses.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx == IDX_W'(k)) begin
                sel_a = REQ_DAT_A[32*k +: 32];
                sel_b = REQ_DAT_B[32*k +: 32];
            end
        end
    end

    // Product is steered to the requester named by the oldest tag.
    always_comb begin
        RSP_STB = '0;
        if (!RST && M_RES_STB && !tag_empty) begin
            RSP_STB[head_tag] = 1'b1;
        end
    end

    assign RSP_DAT   = M_RES_DAT;
    assign M_RES_ACK = !RST && !tag_empty && RSP_ACK[head_tag];
    assign pop       = M_RES_STB && M_RES_ACK;
    assign M_STB     = (state == ISSUE);

    // Next state: grant moves to ISSUE, multiplier acceptance returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (push)  state_nxt = ISSUE;
            ISSUE:   if (M_ACK) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, held operands, tag pointers/count and sticky error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            M_DAT_A <= '0;
            M_DAT_B <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ERR     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) begin
                M_DAT_A <= sel_a;
                M_DAT_B <= sel_b;
                wr_ptr  <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (M_RES_STB && tag_empty) begin
                ERR <= 1'b1;
            end
        end
    end

    // Tag storage; contents are only meaningful between the pointers.
    always_ff @(posedge CLK) begin
        if (push) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - scoreboard bench for mul_share_arbiter
module tb_mul_share_arbiter;

    localparam int N = 4;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    REQ_STB;
    logic [N-1:0]    REQ_ACK;
    logic [32*N-1:0] REQ_DAT_A;
    logic [32*N-1:0] REQ_DAT_B;
    logic [N-1:0]    RSP_STB;
    logic [63:0]     RSP_DAT;
    logic [N-1:0]    RSP_ACK;
    logic            M_STB;
    logic            M_ACK;
    logic [31:0]     M_DAT_A;
    logic [31:0]     M_DAT_B;
    logic            M_RES_STB = 1'b0;
    logic            M_RES_ACK;
    logic [63:0]     M_RES_DAT = '0;
    logic            ERR;

    typedef struct {
        int          idx;
        logic [63:0] prod;
    } exp_t;

    exp_t        exp_grant_q[$];
    exp_t        exp_rsp_q[$];
    logic [63:0] prod_q[$];
    logic        res_stall = 1'b0;
    logic        spurious  = 1'b0;
    int          n_checks  = 0;
    int          n_errors  = 0;

    always #5 CLK = ~CLK;

    mul_share_arbiter #(.N_REQ(N), .TAG_DEPTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_STB   (REQ_STB),
        .REQ_ACK   (REQ_ACK),
        .REQ_DAT_A (REQ_DAT_A),
        .REQ_DAT_B (REQ_DAT_B),
        .RSP_STB   (RSP_STB),
        .RSP_DAT   (RSP_DAT),
        .RSP_ACK   (RSP_ACK),
        .M_STB     (M_STB),
        .M_ACK     (M_ACK),
        .M_DAT_A   (M_DAT_A),
        .M_DAT_B   (M_DAT_B),
        .M_RES_STB (M_RES_STB),
        .M_RES_ACK (M_RES_ACK),
        .M_RES_DAT (M_RES_DAT),
        .ERR       (ERR)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Shared multiplier model: accepts operands, returns products in order.
    always begin : mult_model
        logic        mx;
        logic        rx;
        logic        rs;
        logic [63:0] p;
        @(negedge CLK);
        mx = M_STB && M_ACK;
        rx = M_RES_STB && M_RES_ACK;
        rs = RST;
        p  = {32'b0, M_DAT_A} * {32'b0, M_DAT_B};
        @(posedge CLK);
        #2;
        if (rs) begin
            prod_q.delete();
        end else begin
            if (rx && prod_q.size() > 0) void'(prod_q.pop_front());
            if (mx) prod_q.push_back(p);
        end
        M_RES_STB = (!res_stall && prod_q.size() > 0) || spurious;
        M_RES_DAT = (prod_q.size() > 0) ? prod_q[0] : 64'h1234;
    end

    // Monitor: grants against expected order, products against issue order.
    always @(negedge CLK) begin : monitor
        exp_t         e;
        logic [N-1:0] oh;
        if (REQ_ACK != '0) begin
            if (exp_grant_q.size() == 0) begin
                chk("unexpected_grant", 64'(REQ_ACK), 64'h0);
            end else begin
                e  = exp_grant_q.pop_front();
                oh = '0;
                oh[e.idx] = 1'b1;
                chk("grant", 64'(REQ_ACK), 64'(oh));
                exp_rsp_q.push_back(e);
            end
        end
        if ((RSP_STB & RSP_ACK) != '0) begin
            if (exp_rsp_q.size() == 0) begin
                chk("unexpected_rsp", 64'(RSP_STB), 64'h0);
            end else begin
                e  = exp_rsp_q.pop_front();
                oh = '0;
                oh[e.idx] = 1'b1;
                chk("rsp_stb", 64'(RSP_STB), 64'(oh));
                chk("rsp_dat", RSP_DAT, e.prod);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        REQ_DAT_A[32*i +: 32] = a;
        REQ_DAT_B[32*i +: 32] = b;
    endtask

    task automatic expect_grant(input int idx, input logic [63:0] prod);
        exp_t e;
        e.idx  = idx;
        e.prod = prod;
        exp_grant_q.push_back(e);
    endtask

    task automatic wait_grants(input string name, input int max);
        int n = 0;
        while (exp_grant_q.size() != 0 && n < max) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk(name, 64'(exp_grant_q.size()), 64'h0);
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while ((exp_grant_q.size() != 0 || exp_rsp_q.size() != 0) && n < max) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk(name, 64'(exp_rsp_q.size() + exp_grant_q.size()), 64'h0);
    endtask

    task automatic pulse_reset();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin : stim
        RST       = 1'b1;
        REQ_STB   = '1;
        REQ_DAT_A = '0;
        REQ_DAT_B = '0;
        RSP_ACK   = '1;
        M_ACK     = 1'b1;

        // Reset state, requests held during reset must not be acknowledged
        repeat (3) tick();
        @(negedge CLK);
        chk("rst_req_ack", 64'(REQ_ACK), 64'h0);
        chk("rst_m_stb", 64'(M_STB), 64'h0);
        chk("rst_m_dat_a", 64'(M_DAT_A), 64'h0);
        chk("rst_m_dat_b", 64'(M_DAT_B), 64'h0);
        chk("rst_rsp_stb", 64'(RSP_STB), 64'h0);
        chk("rst_m_res_ack", 64'(M_RES_ACK), 64'h0);
        chk("rst_err", 64'(ERR), 64'h0);
        tick();
        RST     = 1'b0;
        REQ_STB = '0;

        // Single request 3*5 from requester 0
        tick();
        set_ops(0, 32'd3, 32'd5);
        expect_grant(0, 64'd15);
        REQ_STB = 4'b0001;
        @(negedge CLK);
        chk("ack_same_cycle", 64'(REQ_ACK), 64'h1);
        chk("m_stb_before", 64'(M_STB), 64'h0);
        tick();
        REQ_STB = '0;
        @(negedge CLK);
        chk("m_stb_next", 64'(M_STB), 64'h1);
        chk("m_dat_a", 64'(M_DAT_A), 64'd3);
        chk("m_dat_b", 64'(M_DAT_B), 64'd5);
        chk("ack_in_issue", 64'(REQ_ACK), 64'h0);
        wait_drain("single_drain", 40);

        // All four requesting after reset
        pulse_reset();
        set_ops(0, 32'd2, 32'd10);
        set_ops(1, 32'd3, 32'd20);
        set_ops(2, 32'd4, 32'd30);
        set_ops(3, 32'd5, 32'd40);
`ifdef MUL_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 5; i++) expect_grant(0, 64'd20);
`else
        expect_grant(0, 64'd20);
        expect_grant(1, 64'd60);
        expect_grant(2, 64'd120);
        expect_grant(3, 64'd200);
        expect_grant(0, 64'd20);
`endif
        tick();
        REQ_STB = 4'b1111;
        wait_grants("all_req_grants", 40);
        tick();
        REQ_STB = '0;
        wait_drain("all_req_drain", 60);

        // Result port stalled: tag FIFO fills at four grants
        tick();
        res_stall = 1'b1;
`ifdef MUL_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) expect_grant(0, 64'd20);
`else
        expect_grant(1, 64'd60);
        expect_grant(0, 64'd20);
        expect_grant(1, 64'd60);
        expect_grant(0, 64'd20);
`endif
        REQ_STB = 4'b0011;
        wait_grants("fill_grants", 40);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("full_no_ack", 64'(REQ_ACK), 64'h0);
        end
`ifdef MUL_ARB_FIXED_PRIO_EN
        expect_grant(0, 64'd20);
`else
        expect_grant(1, 64'd60);
`endif
        tick();
        res_stall = 1'b0;
        wait_grants("freed_tag_grant", 20);
        tick();
        REQ_STB = '0;
        wait_drain("fill_drain", 60);

        // Largest operands from requester 2
        tick();
        set_ops(2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        expect_grant(2, 64'hFFFFFFFE00000001);
        REQ_STB = 4'b0100;
        wait_grants("max_grant", 10);
        tick();
        REQ_STB = '0;
        wait_drain("max_drain", 40);

        // Consumer back-pressure holds the product without popping
        tick();
        RSP_ACK = '0;
        set_ops(1, 32'd7, 32'd9);
        expect_grant(1, 64'd63);
        REQ_STB = 4'b0010;
        wait_grants("bp_grant", 10);
        tick();
        REQ_STB = '0;
        begin
            int n = 0;
            while (!M_RES_STB && n < 20) begin
                @(negedge CLK);
                n++;
            end
            chk("bp_res_arrives", 64'(M_RES_STB), 64'h1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("bp_m_res_ack", 64'(M_RES_ACK), 64'h0);
            chk("bp_rsp_stb", 64'(RSP_STB), 64'h2);
        end
        tick();
        RSP_ACK = '1;
        wait_drain("bp_drain", 20);

        // Spurious product with no outstanding tag
        pulse_reset();
        @(negedge CLK);
        chk("err_after_rst", 64'(ERR), 64'h0);
        tick();
        spurious = 1'b1;
        tick();
        @(negedge CLK);
        chk("spur_m_res_ack", 64'(M_RES_ACK), 64'h0);
        chk("spur_rsp_stb", 64'(RSP_STB), 64'h0);
        tick();
        spurious = 1'b0;
        @(negedge CLK);
        chk("err_set", 64'(ERR), 64'h1);
        repeat (4) tick();
        @(negedge CLK);
        chk("err_sticky", 64'(ERR), 64'h1);
        pulse_reset();
        @(negedge CLK);
        chk("err_cleared", 64'(ERR), 64'h0);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
